// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP camera-emulation source and the videosampler benches.
// Holds the frame FSM encoding, test pattern codes and small width helpers.
package dvp_pkg;

    localparam int DVP_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } dvp_state_e;

    localparam logic [1:0] PAT_COUNT = 2'd0;
    localparam logic [1:0] PAT_LINE  = 2'd1;
    localparam logic [1:0] PAT_FRAME = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    function automatic int dvp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int dvp_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dvp_pclk_gen.sv
// Free-running pixel clock divider for the DVP source.
// tick_o marks the clk edge on which pclk_o falls; all DVP outputs update there.
module dvp_pclk_gen
    import dvp_pkg::*;
#(
    parameter int PCLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pclk_o,
    output logic tick_o
);

    localparam int               DIV_W    = dvp_cw(PCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_pclk;
    logic             w_term;

    assign w_term = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_pclk    <= 1'b0;
        end else if (w_term) begin
            r_div_cnt <= '0;
            r_pclk    <= ~r_pclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign pclk_o = r_pclk;
    assign tick_o = w_term & r_pclk;

endmodule

// File: rtl/dvp_video_source.sv
// OV-style DVP transmitter: pixel clock, vsync/href frame timing and test patterns.
// Drives the videosampler conduits so the capture path runs without a real sensor.
module dvp_video_source
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE      = 640,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_BLANK       = 144,
    parameter int V_ACTIVE      = 480,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK        = 17,
    parameter int V_FRONT       = 10,
    parameter int PCLK_DIV      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [1:0]            pattern_i,
    output logic                  pclk_o,
    output logic                  vsync_o,
    output logic                  href_o,
    output logic [DVP_DATA_W-1:0] pixel_o,
    output logic                  frame_start_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  busy_o
);

    localparam int ACT_BYTES  = H_ACTIVE * BYTES_PER_PIX;
    localparam int LINE_PCLKS = ACT_BYTES + H_BLANK;
    localparam int COL_W      = dvp_cw(LINE_PCLKS);
    localparam int V_MAX      = dvp_max(dvp_max(V_ACTIVE, VSYNC_LINES), dvp_max(V_BACK, V_FRONT));
    localparam int LIN_W      = dvp_cw(V_MAX);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_PCLKS - 1);
    localparam logic [COL_W:0]   ACT_END  = (COL_W + 1)'(ACT_BYTES);
    localparam logic [LIN_W-1:0] VS_LAST  = LIN_W'(VSYNC_LINES - 1);
    localparam logic [LIN_W-1:0] VB_LAST  = LIN_W'(V_BACK - 1);
    localparam logic [LIN_W-1:0] VA_LAST  = LIN_W'(V_ACTIVE - 1);
    localparam logic [LIN_W-1:0] VF_LAST  = LIN_W'(V_FRONT - 1);

    dvp_state_e       r_state, w_state_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [LIN_W-1:0] r_line, w_line_nxt;
    logic [1:0]       r_pattern, w_pattern_nxt;
    logic [15:0]      r_frame_cnt, w_cnt_nxt;
    logic             r_frame_start;
    logic             w_start;
    logic             w_tick;
    logic             w_col_wrap;
    logic             w_href;
    logic [7:0]       w_c8;
    logic [7:0]       w_l8;
    logic [DVP_DATA_W-1:0] w_pixel;

    dvp_pclk_gen #(
        .PCLK_DIV (PCLK_DIV)
    ) u_pclk_gen (
        .clk    (clk),
        .reset  (reset),
        .pclk_o (pclk_o),
        .tick_o (w_tick)
    );

    assign w_col_wrap = (r_col == COL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_col         <= '0;
            r_line        <= '0;
            r_pattern     <= '0;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_col         <= w_col_nxt;
            r_line        <= w_line_nxt;
            r_pattern     <= w_pattern_nxt;
            r_frame_cnt   <= w_cnt_nxt;
            r_frame_start <= w_start;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_line_nxt    = r_line;
        w_pattern_nxt = r_pattern;
        w_cnt_nxt     = r_frame_cnt;
        w_start       = 1'b0;
        if (w_tick) begin
            if (r_state != IDLE) begin
                w_col_nxt = w_col_wrap ? '0 : r_col + 1'b1;
                if (w_col_wrap) begin
                    w_line_nxt = r_line + 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (enable_i) w_start = 1'b1;
                end
                VSYNC: begin
                    if (w_col_wrap && r_line == VS_LAST) begin
                        w_state_nxt = VBACK;
                        w_line_nxt  = '0;
                    end
                end
                VBACK: begin
                    if (w_col_wrap && r_line == VB_LAST) begin
                        w_state_nxt = ACTIVE;
                        w_line_nxt  = '0;
                    end
                end
                ACTIVE: begin
                    if (w_col_wrap && r_line == VA_LAST) begin
                        w_state_nxt = VFRONT;
                        w_line_nxt  = '0;
                    end
                end
                VFRONT: begin
                    if (w_col_wrap && r_line == VF_LAST) begin
                        w_cnt_nxt = r_frame_cnt + 16'd1;
                        if (enable_i) begin
                            w_start = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_line_nxt  = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
            // A new frame restarts the raster at the first VSYNC pclk.
            if (w_start) begin
                w_state_nxt   = VSYNC;
                w_col_nxt     = '0;
                w_line_nxt    = '0;
                w_pattern_nxt = pattern_i;
            end
        end
    end

    assign w_href = (r_state == ACTIVE) && ({1'b0, r_col} < ACT_END);
    assign w_c8   = 8'(r_col);
    assign w_l8   = 8'(r_line);

    always_comb begin
        w_pixel = '0;
        if (w_href) begin
            case (r_pattern)
                PAT_COUNT: w_pixel = w_c8;
                PAT_LINE:  w_pixel = w_l8;
                PAT_FRAME: w_pixel = r_frame_cnt[7:0];
                PAT_CHECK: w_pixel = (w_c8[3] ^ w_l8[3]) ? 8'hFF : 8'h00;
                default:   w_pixel = '0;
            endcase
        end
    end

    // State-derived outputs only move on tick edges, so they are stable at the pclk rise.
    assign vsync_o       = (r_state == VSYNC);
    assign href_o        = w_href;
    assign pixel_o       = w_pixel;
    assign busy_o        = (r_state != IDLE);
    assign frame_start_o = r_frame_start;
    assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_dvp_video_source.sv
// Scoreboard bench for dvp_video_source at a reduced raster (12 pclk lines, 72 pclk frames).
// Stimulus queues expected pixel bytes; a negedge monitor checks bytes and sync pulses.
module tb_dvp_video_source;
    import dvp_pkg::*;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable_i  = 1'b0;
    logic [1:0]  pattern_i = 2'd0;
    logic        pclk_o;
    logic        vsync_o;
    logic        href_o;
    logic [7:0]  pixel_o;
    logic        frame_start_o;
    logic [15:0] frame_cnt_o;
    logic        busy_o;

    always #5 clk = ~clk;

    dvp_video_source #(
        .H_ACTIVE      (4),
        .BYTES_PER_PIX (2),
        .H_BLANK       (4),
        .V_ACTIVE      (3),
        .VSYNC_LINES   (1),
        .V_BACK        (1),
        .V_FRONT       (1),
        .PCLK_DIV      (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable_i),
        .pattern_i     (pattern_i),
        .pclk_o        (pclk_o),
        .vsync_o       (vsync_o),
        .href_o        (href_o),
        .pixel_o       (pixel_o),
        .frame_start_o (frame_start_o),
        .frame_cnt_o   (frame_cnt_o),
        .busy_o        (busy_o)
    );

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_q[$];
    int         vs_rise_q[$];
    int         cyc = 0;
    int         fs_count = 0;
    int         href_rises = 0;
    int         busy_rise_cyc = 0;
    int         busy_len = 0;
    int         vs_width = 0;
    int         last_vs_width = 0;
    bit         mon_pix_en = 1'b1;
    logic       prev_pclk = 1'b0, prev_vs = 1'b0, prev_fs = 1'b0, prev_href = 1'b0, prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic push_frame(input logic [1:0] pat, input logic [7:0] fc);
        for (int a = 0; a < 3; a++) begin
            for (int c = 0; c < 8; c++) begin
                logic [7:0] b;
                case (pat)
                    2'd0:    b = 8'(c);
                    2'd1:    b = 8'(a);
                    2'd2:    b = fc;
                    default: b = (((c ^ a) >> 3) & 1) != 0 ? 8'hFF : 8'h00;
                endcase
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic clear_stats();
        fs_count   = 0;
        href_rises = 0;
        busy_len   = 0;
        vs_rise_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        enable_i = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        clear_stats();
    endtask

    task automatic pulse_enable(input logic [1:0] pat);
        pattern_i = pat;
        enable_i  = 1'b1;
        repeat (2) @(negedge clk);
        enable_i = 1'b0;
        check("start_busy", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy_o), 32'd0);
    endtask

    // Monitor: pixel bytes at each pclk rise, sync pulse shape, raster statistics.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (mon_pix_en && pclk_o && !prev_pclk && href_o) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL pixel_unexpected: got %02h, required no byte", pixel_o);
                    end else begin
                        check("pixel", 32'(pixel_o), 32'(exp_q.pop_front()));
                    end
                end
                if (frame_start_o) begin
                    fs_count++;
                    check("fs_pulse", {29'd0, prev_fs, vsync_o, prev_vs}, 32'd2);
                end
                if (vsync_o && !prev_vs) begin
                    vs_rise_q.push_back(cyc);
                    vs_width = 0;
                end
                if (vsync_o) vs_width++;
                if (!vsync_o && prev_vs) begin
                    last_vs_width = vs_width;
                    check("vsync_width", 32'(vs_width), 32'd24);
                end
                if (href_o && !prev_href) href_rises++;
                if (busy_o && !prev_busy) busy_rise_cyc = cyc;
                if (!busy_o && prev_busy) busy_len = cyc - busy_rise_cyc;
            end
            prev_pclk = pclk_o;
            prev_vs   = vsync_o;
            prev_fs   = frame_start_o;
            prev_href = href_o;
            prev_busy = busy_o;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, n_fails=%0d", n_fails);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;

        // Reset held with enable low
        repeat (50) @(negedge clk);
        check("rst_pclk", 32'(pclk_o), 32'd0);
        check("rst_vsync", 32'(vsync_o), 32'd0);
        check("rst_href", 32'(href_o), 32'd0);
        check("rst_pixel", 32'(pixel_o), 32'd0);
        check("rst_fs", 32'(frame_start_o), 32'd0);
        check("rst_cnt", 32'(frame_cnt_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("pclk_toggle", 32'(pclk_o), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_vsync", 32'(vsync_o), 32'd0);

        // Single frame, pattern 0
        do_reset();
        push_frame(PAT_COUNT, 8'h00);
        pulse_enable(PAT_COUNT);
        wait_idle("single_idle");
        @(negedge clk);
        check("single_busy_len", 32'(busy_len), 32'd144);
        check("single_cnt", 32'(frame_cnt_o), 32'd1);
        check("single_href_bursts", 32'(href_rises), 32'd3);
        check("single_fs_count", 32'(fs_count), 32'd1);
        check("single_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames, pattern 2
        do_reset();
        push_frame(PAT_FRAME, 8'h00);
        push_frame(PAT_FRAME, 8'h01);
        push_frame(PAT_FRAME, 8'h02);
        pattern_i = PAT_FRAME;
        enable_i  = 1'b1;
        n = 0;
        while (fs_count < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_start3", 32'(fs_count), 32'd3);
        enable_i = 1'b0;
        wait_idle("b2b_idle");
        @(negedge clk);
        check("b2b_cnt", 32'(frame_cnt_o), 32'd3);
        check("b2b_vs_rises", 32'(vs_rise_q.size()), 32'd3);
        if (vs_rise_q.size() == 3) begin
            check("b2b_period0", 32'(vs_rise_q[1] - vs_rise_q[0]), 32'd144);
            check("b2b_period1", 32'(vs_rise_q[2] - vs_rise_q[1]), 32'd144);
        end
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Pattern and enable changed during ACTIVE line 1
        do_reset();
        push_frame(PAT_LINE, 8'h00);
        pattern_i = PAT_LINE;
        enable_i  = 1'b1;
        n = 0;
        while (href_rises < 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("mid_line1", 32'(href_rises), 32'd2);
        pattern_i = PAT_CHECK;
        enable_i  = 1'b0;
        wait_idle("mid_idle");
        repeat (300) @(negedge clk);
        check("mid_no_restart", 32'(busy_o), 32'd0);
        check("mid_vs_rises", 32'(vs_rise_q.size()), 32'd1);
        check("mid_cnt", 32'(frame_cnt_o), 32'd1);
        check("mid_q_empty", 32'(exp_q.size()), 32'd0);

        // Frame counter wrap
        do_reset();
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        check("wrap_preload", 32'(frame_cnt_o), 32'h0000FFFF);
        push_frame(PAT_FRAME, 8'hFF);
        pulse_enable(PAT_FRAME);
        wait_idle("wrap_idle");
        check("wrap_cnt", 32'(frame_cnt_o), 32'd0);
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid-ACTIVE, then a clean restart
        do_reset();
        mon_pix_en = 1'b0;
        pattern_i  = PAT_COUNT;
        enable_i   = 1'b1;
        n = 0;
        while (!href_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("href_before_reset", 32'(href_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_vsync", 32'(vsync_o), 32'd0);
        check("async_href", 32'(href_o), 32'd0);
        check("async_pixel", 32'(pixel_o), 32'd0);
        check("async_busy", 32'(busy_o), 32'd0);
        check("async_pclk", 32'(pclk_o), 32'd0);
        enable_i = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        mon_pix_en = 1'b1;
        reset = 1'b0;
        clear_stats();
        push_frame(PAT_COUNT, 8'h00);
        pulse_enable(PAT_COUNT);
        check("restart_vsync", 32'(vsync_o), 32'd1);
        wait_idle("restart_idle");
        check("restart_vs_width", 32'(last_vs_width), 32'd24);
        check("restart_cnt", 32'(frame_cnt_o), 32'd1);
        check("restart_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dvp_video_source.md
Name: dvp_video_source

Overview:
- Camera-side transmitter for the parallel DVP interface (pclk, vsync, href, 8-bit pixel) that videosampler_0 receives.
- Emulates an OV-style sensor so the sampler → USB streaming path can be exercised on hardware and in simulation without a real camera.
- Generates a free-running pixel clock, frame and line timing, and selectable deterministic test patterns.
- Instantiated in the test top beside the Nios system; its outputs drive the videosampler conduits.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- BYTES_PER_PIX, 2, bytes sent per pixel (RGB565 = 2).
- H_BLANK, 144, pclk periods per line with href low.
- V_ACTIVE, 480, active lines per frame.
- VSYNC_LINES, 3, lines with vsync high.
- V_BACK, 17, blank lines after vsync.
- V_FRONT, 10, blank lines after active.
- PCLK_DIV, 2, clk cycles per pclk half-period (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  start/continue frame generation.
- pattern_i  in  2  test pattern select.
- pclk_o  out  1  generated pixel clock.
- vsync_o  out  1  frame sync, active high.
- href_o  out  1  line valid, active high.
- pixel_o  out  8  pixel byte.
- frame_start_o  out  1  one-clk pulse when vsync rises.
- frame_cnt_o  out  16  completed frames.
- busy_o  out  1  high while a frame is in progress.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Asserting reset mid-frame forces the outputs to 0 immediately (asynchronous).
- Pixel clock:
  - div_cnt counts 0..PCLK_DIV-1; at terminal count pclk_o toggles; runs continuously after reset.
  - Period = 2*PCLK_DIV clk cycles.
  - A "tick" is the clk edge on which pclk_o goes 1→0.
  - vsync_o, href_o and pixel_o change only on ticks, so the sampler captures them on the pclk rising edge.
- Line timing:
  - LINE_PCLKS = H_ACTIVE*BYTES_PER_PIX + H_BLANK.
  - col counts ticks 0..LINE_PCLKS-1 and wraps.
  - line advances on col wrap.
- FSM (all transitions on ticks):
  - IDLE: outputs low. Sample enable_i on each tick; if 1, latch pattern_i, assert vsync_o, pulse frame_start_o, busy_o=1, col=line=0, go to VSYNC.
  - VSYNC: vsync_o=1 for VSYNC_LINES full lines, then → VBACK.
  - VBACK: V_BACK lines, all low, then → ACTIVE.
  - ACTIVE: href_o=1 while col < H_ACTIVE*BYTES_PER_PIX, else 0; V_ACTIVE lines, then → VFRONT.
  - VFRONT: V_FRONT lines. On its last tick, frame_cnt_o increments (16-bit wrap, FFFF→0000). Then if enable_i=1, start a new frame exactly as from IDLE (back-to-back, no gap); else → IDLE with busy_o=0.
- Enable and pattern handling:
  - Deasserting enable_i mid-frame does not truncate; the current frame completes.
  - pattern_i changes mid-frame have no effect; the pattern is latched at frame start.
- Pixel data (a = active line index, c = byte index in line):
  - pattern 0: c[7:0].
  - pattern 1: a[7:0].
  - pattern 2: frame_cnt_o[7:0].
  - pattern 3: (c[3]^a[3]) ? FF : 00.
  - pixel_o = 00 whenever href_o=0.
- frame_start_o is exactly one clk wide, coincident with vsync_o rising.
- Counter widths derive from parameters via $clog2; no truncation at defaults.

Decomposition:
- Shared package dvp_pkg:
  - FSM state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT).
  - Pattern code constants PAT_COUNT, PAT_LINE, PAT_FRAME, PAT_CHECK.
  - DVP_DATA_W = 8.
  - Reused by videosampler benches.
- One sub-module: dvp_pclk_gen. Contains the divider, pclk_o and the tick strobe.
- Timing FSM and pattern mux stay in the top module.

Test Plan (common parameters: H_ACTIVE=4, BYTES_PER_PIX=2, H_BLANK=4, V_ACTIVE=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_DIV=1 → line = 12 pclk, frame = 72 pclk = 144 clk):
- Reset/idle: reset held, enable_i=0 for 50 clk → all outputs 0; pclk_o toggles every clk after reset release.
- Single frame, pattern 0: pulse enable_i for 1 pclk.
  - frame_start_o is a single 1-clk pulse.
  - vsync_o high for 12 pclk.
  - 3 href bursts of 8 pclk, each carrying bytes 00..07.
  - busy_o falls after 144 clk; frame_cnt_o = 1.
- Back-to-back, pattern 2: enable_i held high for 3 frames.
  - vsync_o rises every 72 pclk with no idle gap.
  - Frame bytes are all 00, then 01, then 02.
  - frame_cnt_o = 3.
- Mid-frame changes: pattern_i 1→3 and enable_i dropped during line 1 of ACTIVE.
  - The frame completes using pattern 1 (line bytes 00, 01, 02).
  - No next frame starts.
- Wrap: force frame_cnt_o to FFFF, run one frame → 0000.
- Reset mid-ACTIVE: assert reset while href_o=1 → outputs 0 within the same clk; restart after release begins with a full VSYNC.
